// File: rtl/slink_tx_align_serializer.sv
// S-Link TX lane serializer: parallel words to an LSB-first serial stream on bitclk,
// with the divided word clock and the word-alignment training pattern injected on request.
module slink_tx_align_serializer #(
  parameter int DATA_WIDTH  = 8,
  parameter int TRAIN_WORDS = 16
) (
  input  logic                  bitclk,
  input  logic                  tx_reset,
  input  logic                  enable,
  input  logic                  train_req,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_accept,
  output logic                  txclk,
  output logic                  training,
  output logic                  tx_ready,
  output logic                  txp,
  output logic                  txn
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int TC_W  = $clog2(TRAIN_WORDS + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DATA_WIDTH / 2);
  localparam logic [TC_W-1:0]  TC_MAX   = TC_W'(TRAIN_WORDS);
  localparam logic [TC_W-1:0]  TC_EXIT  = TC_W'(TRAIN_WORDS - 1);

  localparam logic [1:0] ST_OFF   = 2'd0;
  localparam logic [1:0] ST_TRAIN = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;

  // Comma byte BC in the low byte so the receiver sees it first, 55 fill above it.
  function automatic logic [DATA_WIDTH-1:0] train_pattern();
    logic [DATA_WIDTH-1:0] p;
    p = '0;
    for (int b = 0; b < DATA_WIDTH / 8; b++) begin
      p[8*b +: 8] = (b == 0) ? 8'hBC : 8'h55;
    end
    return p;
  endfunction

  localparam logic [DATA_WIDTH-1:0] PAT = train_pattern();

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic [CNT_W-1:0]      count;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] shreg_nxt;
  logic [TC_W-1:0]       train_cnt;
  logic [TC_W-1:0]       train_cnt_nxt;
  logic                  accept_nxt;
  logic                  boundary;
  logic                  line_on;
  logic                  bit_now;

  assign boundary = (count == CNT_LAST);

  // Word-boundary decisions; between boundaries everything holds.
  always_comb begin
    state_nxt     = state;
    shreg_nxt     = shreg;
    train_cnt_nxt = train_cnt;
    accept_nxt    = 1'b0;
    if (boundary) begin
      case (state)
        ST_OFF: begin
          shreg_nxt = '0;
          if (enable) begin
            state_nxt     = ST_TRAIN;
            train_cnt_nxt = '0;
          end
        end
        ST_TRAIN: begin
          shreg_nxt = PAT;
          if (train_cnt != TC_MAX) begin
            train_cnt_nxt = train_cnt + 1'b1;
          end
          if (!enable) begin
            state_nxt = ST_OFF;
          end else if ((train_cnt >= TC_EXIT) && !train_req) begin
            state_nxt = ST_DATA;
          end
        end
        ST_DATA: begin
          if (!enable) begin
            state_nxt = ST_OFF;
            shreg_nxt = '0;
          end else if (train_req) begin
            state_nxt     = ST_TRAIN;
            train_cnt_nxt = '0;
            shreg_nxt     = PAT;
          end else if (tx_valid) begin
            shreg_nxt  = tx_data;
            accept_nxt = 1'b1;
          end else begin
            shreg_nxt = PAT;
          end
        end
        default: begin
          state_nxt = ST_OFF;
          shreg_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge bitclk or posedge tx_reset) begin
    if (tx_reset) begin
      state     <= ST_OFF;
      count     <= '0;
      shreg     <= '0;
      train_cnt <= '0;
      tx_accept <= 1'b0;
      training  <= 1'b0;
      tx_ready  <= 1'b0;
    end else begin
      count     <= boundary ? '0 : count + 1'b1;
      state     <= state_nxt;
      shreg     <= shreg_nxt;
      train_cnt <= train_cnt_nxt;
      tx_accept <= accept_nxt;
      training  <= (state_nxt == ST_TRAIN);
      tx_ready  <= (state_nxt == ST_DATA);
    end
  end

  // OFF is electrical idle: both legs low rather than a differential zero.
  assign line_on = (state != ST_OFF);
  assign bit_now = shreg[count];
  assign txp     = line_on & bit_now;
  assign txn     = line_on & ~bit_now;
  assign txclk   = (count < CNT_HALF);

endmodule

// File: tb/tb_slink_tx_align_serializer.sv
// Directed bench for slink_tx_align_serializer: an 8-bit lane with 4 training words
// and a 16-bit lane with 2 training words, checked bit by bit against hand-derived words.
module tb_slink_tx_align_serializer;

  logic bitclk = 1'b0;
  always #5 bitclk = ~bitclk;

  logic       tx_reset, enable, train_req, tx_valid;
  logic [7:0] tx_data;
  logic       tx_accept, txclk, training, tx_ready, txp, txn;

  logic        rst2, en2, treq2, valid2;
  logic [15:0] data2;
  logic        acc2, txclk2, training2, ready2, txp2, txn2;

  int total = 0;
  int bad   = 0;
  int mcount = 0;
  int m2     = 0;
  int cyc    = 0;

  slink_tx_align_serializer #(.DATA_WIDTH(8), .TRAIN_WORDS(4)) dut (
    .bitclk(bitclk), .tx_reset(tx_reset), .enable(enable), .train_req(train_req),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_accept(tx_accept), .txclk(txclk),
    .training(training), .tx_ready(tx_ready), .txp(txp), .txn(txn)
  );

  slink_tx_align_serializer #(.DATA_WIDTH(16), .TRAIN_WORDS(2)) dut_wide (
    .bitclk(bitclk), .tx_reset(rst2), .enable(en2), .train_req(treq2),
    .tx_data(data2), .tx_valid(valid2), .tx_accept(acc2), .txclk(txclk2),
    .training(training2), .tx_ready(ready2), .txp(txp2), .txn(txn2)
  );

  // One bitclk edge; the bench's own bit counters follow the lanes' counters.
  task automatic tick();
    @(posedge bitclk);
    #1;
    if (!tx_reset) mcount = (mcount + 1) % 8;
    if (!rst2) m2 = (m2 + 1) % 16;
    cyc++;
  endtask

  task automatic test_reset();
    tx_reset = 1'b1; enable = 1'b0; train_req = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    rst2 = 1'b1; en2 = 1'b0; treq2 = 1'b0; valid2 = 1'b0; data2 = 16'h0000;
    repeat (3) tick();
    total++; if (txp !== 1'b0 || txn !== 1'b0) begin bad++; $display("FAIL reset_pins: txp=%b txn=%b want 0 0", txp, txn); end
    total++; if (tx_accept !== 1'b0) begin bad++; $display("FAIL reset_accept: got %b want 0", tx_accept); end
    total++; if (training !== 1'b0 || tx_ready !== 1'b0) begin bad++; $display("FAIL reset_status: training=%b tx_ready=%b want 0 0", training, tx_ready); end
    total++; if (txclk !== 1'b1) begin bad++; $display("FAIL reset_txclk: got %b want 1", txclk); end
    tx_reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      total++; if (txp !== 1'b0 || txn !== 1'b0) begin bad++; $display("FAIL idle_pins cyc %0d: txp=%b txn=%b want 0 0", cyc, txp, txn); end
      total++; if (txclk !== logic'(mcount < 4)) begin bad++; $display("FAIL idle_txclk cyc %0d: got %b want %b", cyc, txclk, mcount < 4); end
      total++; if (training !== 1'b0 || tx_ready !== 1'b0) begin bad++; $display("FAIL idle_status cyc %0d: training=%b tx_ready=%b want 0 0", cyc, training, tx_ready); end
    end
  endtask

  task automatic test_training();
    logic [7:0] pat;
    pat = 8'hBC;
    enable = 1'b1;
    do tick(); while (mcount != 0);
    // First TRAIN word carries the zeros loaded while still OFF.
    for (int k = 0; k < 8; k++) begin
      total++; if (txp !== 1'b0 || txn !== 1'b1) begin bad++; $display("FAIL train_lead bit %0d: txp=%b txn=%b want 0 1", k, txp, txn); end
      if (k == 0) begin
        total++; if (training !== 1'b1 || tx_ready !== 1'b0) begin bad++; $display("FAIL train_enter: training=%b tx_ready=%b want 1 0", training, tx_ready); end
      end
      tick();
    end
    for (int w = 0; w < 4; w++) begin
      for (int k = 0; k < 8; k++) begin
        total++; if (txp !== pat[k] || txn !== ~pat[k]) begin bad++; $display("FAIL train_pat word %0d bit %0d: txp=%b txn=%b want %b %b", w, k, txp, txn, pat[k], ~pat[k]); end
        if (k == 0) begin
          total++; if (training !== logic'(w < 3) || tx_ready !== logic'(w == 3)) begin bad++; $display("FAIL train_status word %0d: training=%b tx_ready=%b want %b %b", w, training, tx_ready, w < 3, w == 3); end
        end
        tick();
      end
    end
  endtask

  task automatic test_datapath();
    logic [7:0] words [3];
    int acc_cyc [2];
    words[0] = 8'hBC; words[1] = 8'hA5; words[2] = 8'h3C;
    acc_cyc[0] = 0; acc_cyc[1] = 0;
    tx_data = 8'hA5; tx_valid = 1'b1;
    for (int w = 0; w < 3; w++) begin
      for (int k = 0; k < 8; k++) begin
        total++; if (tx_accept !== logic'(k == 0 && w > 0)) begin bad++; $display("FAIL data_accept word %0d bit %0d: got %b want %b", w, k, tx_accept, k == 0 && w > 0); end
        total++; if (txp !== words[w][k] || txn !== ~words[w][k]) begin bad++; $display("FAIL data_bits word %0d bit %0d: txp=%b txn=%b want %b %b", w, k, txp, txn, words[w][k], ~words[w][k]); end
        if (k == 0 && w > 0 && tx_accept === 1'b1) acc_cyc[w-1] = cyc;
        if (k == 0 && w == 1) tx_data = 8'h3C;
        if (k == 0 && w == 2) tx_valid = 1'b0;
        tick();
      end
    end
    total++; if (acc_cyc[1] - acc_cyc[0] !== 8) begin bad++; $display("FAIL accept_spacing: got %0d want 8", acc_cyc[1] - acc_cyc[0]); end
  endtask

  task automatic test_filler();
    logic [7:0] pat;
    pat = 8'hBC;
    for (int w = 0; w < 3; w++) begin
      for (int k = 0; k < 8; k++) begin
        total++; if (txp !== pat[k] || txn !== ~pat[k]) begin bad++; $display("FAIL filler_bits word %0d bit %0d: txp=%b txn=%b want %b %b", w, k, txp, txn, pat[k], ~pat[k]); end
        total++; if (tx_accept !== 1'b0 || tx_ready !== 1'b1) begin bad++; $display("FAIL filler_status word %0d bit %0d: tx_accept=%b tx_ready=%b want 0 1", w, k, tx_accept, tx_ready); end
        tick();
      end
    end
  endtask

  task automatic test_retrain();
    logic [7:0] pat;
    logic [7:0] dw;
    pat = 8'hBC; dw = 8'h0F;
    tx_data = 8'h0F; tx_valid = 1'b1;
    repeat (8) tick();
    // Data word 0F: train_req rises mid-word, the word still completes.
    for (int k = 0; k < 8; k++) begin
      if (k == 0) begin
        total++; if (tx_accept !== 1'b1) begin bad++; $display("FAIL retrain_accept: got %b want 1", tx_accept); end
        tx_valid = 1'b0;
      end
      if (k == 3) train_req = 1'b1;
      total++; if (txp !== dw[k] || training !== 1'b0) begin bad++; $display("FAIL retrain_finish bit %0d: txp=%b training=%b want %b 0", k, txp, training, dw[k]); end
      tick();
    end
    for (int p = 0; p < 5; p++) begin
      for (int k = 0; k < 8; k++) begin
        if (p == 0 && k == 2) train_req = 1'b0;
        total++; if (txp !== pat[k] || txn !== ~pat[k]) begin bad++; $display("FAIL retrain_pat word %0d bit %0d: txp=%b txn=%b want %b %b", p, k, txp, txn, pat[k], ~pat[k]); end
        if (k == 0) begin
          total++; if (training !== logic'(p < 4) || tx_ready !== logic'(p == 4)) begin bad++; $display("FAIL retrain_status word %0d: training=%b tx_ready=%b want %b %b", p, training, tx_ready, p < 4, p == 4); end
        end
        tick();
      end
    end
  endtask

  task automatic test_disable();
    logic [7:0] dw;
    dw = 8'h96;
    tx_data = 8'h96; tx_valid = 1'b1;
    repeat (8) tick();
    // Enable drops together with a train request mid-word: the word finishes, then OFF.
    for (int k = 0; k < 8; k++) begin
      if (k == 0) begin
        total++; if (tx_accept !== 1'b1) begin bad++; $display("FAIL disable_accept: got %b want 1", tx_accept); end
        tx_valid = 1'b0;
      end
      if (k == 4) begin enable = 1'b0; train_req = 1'b1; end
      total++; if (txp !== dw[k] || txn !== ~dw[k] || tx_ready !== 1'b1) begin bad++; $display("FAIL disable_finish bit %0d: txp=%b txn=%b tx_ready=%b want %b %b 1", k, txp, txn, tx_ready, dw[k], ~dw[k]); end
      tick();
    end
    for (int k = 0; k < 8; k++) begin
      total++; if (txp !== 1'b0 || txn !== 1'b0) begin bad++; $display("FAIL disable_idle bit %0d: txp=%b txn=%b want 0 0", k, txp, txn); end
      total++; if (tx_ready !== 1'b0 || training !== 1'b0 || tx_accept !== 1'b0) begin bad++; $display("FAIL disable_status bit %0d: tx_ready=%b training=%b tx_accept=%b want 0 0 0", k, tx_ready, training, tx_accept); end
      tick();
    end
    train_req = 1'b0;
  endtask

  task automatic test_reset_midword();
    enable = 1'b1;
    do tick(); while (mcount != 0);
    total++; if (training !== 1'b1) begin bad++; $display("FAIL midreset_pre: training=%b want 1", training); end
    repeat (3) tick();
    tx_reset = 1'b1;
    #1;
    total++; if (training !== 1'b0 || tx_ready !== 1'b0) begin bad++; $display("FAIL midreset_status: training=%b tx_ready=%b want 0 0", training, tx_ready); end
    total++; if (txp !== 1'b0 || txn !== 1'b0) begin bad++; $display("FAIL midreset_pins: txp=%b txn=%b want 0 0", txp, txn); end
    total++; if (txclk !== 1'b1) begin bad++; $display("FAIL midreset_txclk: got %b want 1", txclk); end
    tick();
    tx_reset = 1'b0;
    mcount = 0;
    tick();
    total++; if (training !== 1'b0 || txn !== 1'b0) begin bad++; $display("FAIL midreset_release: training=%b txn=%b want 0 0", training, txn); end
    do tick(); while (mcount != 0);
    total++; if (training !== 1'b1 || txn !== 1'b1) begin bad++; $display("FAIL midreset_retrain: training=%b txn=%b want 1 1", training, txn); end
  endtask

  task automatic test_wide();
    logic [15:0] pat;
    pat = 16'h55BC;
    en2 = 1'b1;
    rst2 = 1'b0;
    do tick(); while (m2 != 0);
    for (int k = 0; k < 16; k++) begin
      total++; if (txp2 !== 1'b0 || txn2 !== 1'b1) begin bad++; $display("FAIL wide_lead bit %0d: txp=%b txn=%b want 0 1", k, txp2, txn2); end
      total++; if (txclk2 !== logic'(m2 < 8)) begin bad++; $display("FAIL wide_txclk bit %0d: got %b want %b", k, txclk2, m2 < 8); end
      tick();
    end
    for (int w = 0; w < 2; w++) begin
      for (int k = 0; k < 16; k++) begin
        total++; if (txp2 !== pat[k] || txn2 !== ~pat[k]) begin bad++; $display("FAIL wide_pat word %0d bit %0d: txp=%b txn=%b want %b %b", w, k, txp2, txn2, pat[k], ~pat[k]); end
        if (k == 0) begin
          total++; if (training2 !== logic'(w == 0) || ready2 !== logic'(w == 1)) begin bad++; $display("FAIL wide_status word %0d: training=%b tx_ready=%b want %b %b", w, training2, ready2, w == 0, w == 1); end
        end
        tick();
      end
    end
  endtask

  initial begin
    test_reset();
    test_training();
    test_datapath();
    test_filler();
    test_retrain();
    test_disable();
    test_reset_midword();
    test_wide();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/slink_tx_align_serializer.md
# slink_tx_align_serializer

Transmit-side lane serializer for the S-Link SerDes path: turns DATA_WIDTH-bit parallel words into a serial LSB-first bit stream on bitclk, generates the lane's divided txclk, and injects the word-alignment training pattern that the receive-side aligner locks on. There is one instance per TX lane, between the link layer's parallel TX interface and the differential txp/txn pins.

## Interface
Parameters:
- DATA_WIDTH, 8, serial word width; multiple of 8, ≥ 8
- TRAIN_WORDS, 16, minimum pattern words sent per training burst; ≥ 1

Ports:
- bitclk  in  1  serial bit clock; all state on rising edge
- tx_reset  in  1  asynchronous, active-high reset
- enable  in  1  lane enable (level)
- train_req  in  1  request training burst (level)
- tx_data  in  DATA_WIDTH  parallel word, bit 0 transmitted first
- tx_valid  in  1  tx_data holds a word to send
- tx_accept  out  1  one-bitclk pulse: tx_data taken this edge
- txclk  out  1  word clock, high for count < DATA_WIDTH/2
- training  out  1  high while in TRAIN
- tx_ready  out  1  high while in DATA
- txp  out  1  serial data, true
- txn  out  1  serial data, complement

## Operation
- Reset clock and reset: reset tx_reset, asynchronous, active-high; clock bitclk.
- Bit counter `count` runs 0..DATA_WIDTH-1 and wraps to 0. It runs in every state after reset. The word boundary is the edge where count == DATA_WIDTH-1.
- Pattern word PAT = {(DATA_WIDTH/8-1) copies of 8'h55, 8'hBC}, with BC in bits [7:0] so it goes out first. For DATA_WIDTH=8, PAT = 8'hBC.
- The shift register `shreg` loads only at the word boundary.
- State machine, evaluated only at the word boundary:
  - OFF: shreg loads 0. If enable is high, go to TRAIN and clear train_cnt.
  - TRAIN: shreg loads PAT and train_cnt increments, saturating at TRAIN_WORDS.
    - If enable is low, go to OFF.
    - Otherwise, if train_cnt has reached TRAIN_WORDS−1 or higher before this load and train_req is low, go to DATA.
  - DATA:
    - If enable is low, go to OFF and load 0.
    - Otherwise, if train_req is high, go to TRAIN, clear train_cnt, and load PAT.
    - Otherwise, if tx_valid is high, load tx_data and pulse tx_accept.
    - Otherwise, load PAT as filler.
- Mid-word changes on any input have no effect until the next boundary. The current word always finishes.
- Simultaneous enable low and train_req high: enable wins, go to OFF.
- train_req held high in TRAIN keeps the lane in TRAIN indefinitely, sending PAT continuously.
- txp = shreg[count] when state is not OFF, else 0. txn = ~txp when state is not OFF, else 0. OFF is electrical idle: both pins low.
- training = (state == TRAIN). tx_ready = (state == DATA). Both are registered from state.
- tx_accept is a registered pulse, high for exactly the one bitclk cycle after the boundary edge that loaded tx_data.

## Timing
- Reset values:
  - state OFF, count 0, shreg 0, train_cnt 0
  - txp 0, txn 0, tx_accept 0, training 0, tx_ready 0
  - txclk 1, since count 0 < DATA_WIDTH/2
- Reset asserted mid-word: all of the above apply immediately. The partial word is discarded.
- Parallel-to-serial latency: a word loaded at boundary edge E drives bit 0 on txp during the cycle after E. Bit k follows at E+k, and bit DATA_WIDTH-1 at E+DATA_WIDTH-1.
- Word rate: one word per DATA_WIDTH bitclk cycles. The txclk rising edge coincides with count becoming 0, so tx_data sampled on the txclk domain is stable at the boundary.
- TRAIN duration is at least TRAIN_WORDS words. The first data word follows the last PAT word with no gap.
- Enable deassertion takes effect at the first boundary at or after the deassertion. txp/txn go to 0 from the cycle after that boundary.
- tx_valid/tx_data must be held until tx_accept. The block never drops an accepted word.

## Test plan
- Reset: assert tx_reset for 3 cycles, then release with enable=0. Expect txp=txn=0, tx_ready=0, training=0, and txclk toggling with period DATA_WIDTH.
- Training (DATA_WIDTH=8, TRAIN_WORDS=4): raise enable. Expect training=1 at the next boundary, then exactly 4 words of 8'hBC LSB-first (bits 0,0,1,1,1,1,0,1), then tx_ready=1.
- Data path: in DATA, present tx_valid with 8'hA5, 8'h3C. Expect tx_accept pulses 8 cycles apart, and txp serializes 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0, with txn the exact complement.
- Filler: in DATA with tx_valid=0 for 3 words. Expect 3 × 8'hBC on txp, tx_accept=0, tx_ready stays 1.
- Retrain and disable: pulse train_req mid-word in DATA. Expect the current word to finish, then ≥4 PAT words with training=1. Drop enable mid-word: expect the word to finish, then txp=txn=0 and tx_ready=0.
- Wide lane (DATA_WIDTH=16): check that the training word is 16'h55BC, transmitted with the BC byte first.
